// File: rtl/prng_pkg.sv
// Shared definitions for the bounded-random sampling path.
// Contents:
//   DefaultWidth  - default data width of random words, bounds and outputs
//   MaskCalcWidth - widest bound calc_mask can handle
//   state_e       - sampler control states (CFG, RUN)
//   calc_mask     - smallest all-ones mask covering bound-1 (all-ones when bound is 0)
package prng_pkg;

   localparam int unsigned DefaultWidth  = 32;
   localparam int unsigned MaskCalcWidth = 64;

   typedef enum logic [0:0] {
      CFG,
      RUN
   } state_e;

   // Fold every set bit of bound-1 downwards, which gives the smallest 2^k-1 >= bound-1.
   function automatic logic [MaskCalcWidth-1:0] calc_mask(input logic [MaskCalcWidth-1:0] bound);
      logic [MaskCalcWidth-1:0] m;
      if (bound == '0) begin
         return '1;
      end
      m = bound - MaskCalcWidth'(1);
      m = m | (m >> 1);
      m = m | (m >> 2);
      m = m | (m >> 4);
      m = m | (m >> 8);
      m = m | (m >> 16);
      m = m | (m >> 32);
      return m;
   endfunction

endpackage

// File: rtl/rand_fifo.sv
// Synchronous FIFO holding accepted sample values.
// Ports:
//   clk, rst          - clock, synchronous active-high reset
//   push, push_data   - write request and data (ignored when full)
//   pop               - read request (ignored when empty)
//   flush             - empty the FIFO; overrides push and pop
//   full, empty       - occupancy flags
//   count             - number of stored entries, 0..FIFO_DEPTH
//   head_data         - oldest entry; holds the last head value while empty
module rand_fifo #(
   parameter int unsigned WIDTH      = 32,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [WIDTH-1:0]            push_data,
   input  logic                        pop,
   input  logic                        flush,
   output logic                        full,
   output logic                        empty,
   output logic [$clog2(FIFO_DEPTH):0] count,
   output logic [WIDTH-1:0]            head_data
);

   localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
   localparam int unsigned CntW = PtrW + 1;

   logic [WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
   logic [CntW-1:0]  count_q;
   logic [WIDTH-1:0] hold_q;
   logic             do_push, do_pop;

   assign full      = (count_q == CntW'(FIFO_DEPTH));
   assign empty     = (count_q == '0);
   assign do_push   = push && !full && !flush;
   assign do_pop    = pop && !empty && !flush;
   assign count     = count_q;
   // hold_q keeps the most recent head so the output does not show stale slots when empty.
   assign head_data = empty ? hold_q : mem_q[rd_ptr_q];

   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         hold_q   <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         if (!empty) begin
            hold_q <= mem_q[rd_ptr_q];
         end
      end else begin
         if (do_push) begin
            wr_ptr_q <= wr_ptr_q + PtrW'(1);
         end
         if (do_pop) begin
            hold_q   <= mem_q[rd_ptr_q];
            rd_ptr_q <= rd_ptr_q + PtrW'(1);
         end
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CntW'(1);
            2'b01:   count_q <= count_q - CntW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/rand_range_sampler.sv
// Maps raw 32-bit random words to uniform values in [0, bound) by power-of-two
// masking plus rejection, buffering accepted values in a small FIFO.
// Ports:
//   clk, rst            - clock, synchronous active-high reset
//   bound_wr, bound_in  - strobe loading a new exclusive bound (0 = full range)
//   in_valid, in_data   - random word from the generator stage
//   in_ready            - word consumed when in_valid && in_ready
//   out_valid, out_data - FIFO head
//   out_ready           - downstream pop
//   reject_count        - saturating count of rejected words since reset / bound write
module rand_range_sampler
   import prng_pkg::*;
#(
   parameter int unsigned WIDTH      = DefaultWidth,
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 bound_wr,
   input  logic [WIDTH-1:0]     bound_in,
   input  logic                 in_valid,
   input  logic [WIDTH-1:0]     in_data,
   output logic                 in_ready,
   output logic                 out_valid,
   output logic [WIDTH-1:0]     out_data,
   input  logic                 out_ready,
   output logic [CNT_WIDTH-1:0] reject_count
);

   state_e                      state_q, state_d;
   logic [WIDTH-1:0]            bound_q;
   logic [WIDTH-1:0]            mask_q;
   logic [CNT_WIDTH-1:0]        reject_q;
   logic [WIDTH-1:0]            cand;
   logic                        in_hs, accept;
   logic                        fifo_full, fifo_empty;
   logic [$clog2(FIFO_DEPTH):0] fifo_count;
   logic                        unused_fifo_count;

   assign unused_fifo_count = ^fifo_count;

   // A bound write pre-empts any input handshake in the same cycle.
   assign in_ready     = (state_q == RUN) && !fifo_full && !bound_wr;
   assign in_hs        = in_valid && in_ready;
   assign cand         = in_data & mask_q;
   assign accept       = (bound_q == '0) || (cand < bound_q);
   assign out_valid    = !fifo_empty;
   assign reject_count = reject_q;

   always_comb begin
      state_d = state_q;
      if (bound_wr) begin
         state_d = CFG;
      end else if (state_q == CFG) begin
         state_d = RUN;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= CFG;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bound_q  <= '0;
         mask_q   <= '1;
         reject_q <= '0;
      end else begin
         if (bound_wr) begin
            bound_q <= bound_in;
         end
         // Mask follows the bound register only while configuring; a bound write
         // landing in CFG re-enters CFG, so the new bound is captured next cycle.
         if (state_q == CFG) begin
            mask_q <= WIDTH'(calc_mask(MaskCalcWidth'(bound_q)));
         end
         if (bound_wr) begin
            reject_q <= '0;
         end else if (in_hs && !accept && (reject_q != {CNT_WIDTH{1'b1}})) begin
            reject_q <= reject_q + CNT_WIDTH'(1);
         end
      end
   end

   rand_fifo #(
      .WIDTH      (WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (in_hs && accept),
      .push_data (cand),
      .pop       (out_ready),
      .flush     (bound_wr),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count),
      .head_data (out_data)
   );

endmodule
